// File: rtl/sfx_pkg.sv
// Shared types and note tables for the sound-effect sequencer.
// Note ROM values are raw half-periods in clock cycles; the sequencer applies any scaling.
package sfx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] EFF_NONE  = 2'd0;
    localparam logic [1:0] EFF_JUMP  = 2'd1;
    localparam logic [1:0] EFF_SCORE = 2'd2;
    localparam logic [1:0] EFF_KILL  = 2'd3;

    function automatic logic [2:0] note_count(input logic [1:0] eff);
        case (eff)
            EFF_JUMP:  return 3'd2;
            EFF_SCORE: return 3'd3;
            EFF_KILL:  return 3'd4;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic logic [18:0] get_half(input logic [1:0] eff, input logic [1:0] idx);
        case ({eff, idx})
            {EFF_JUMP,  2'd0}: return 19'd19113;
            {EFF_JUMP,  2'd1}: return 19'd12755;
            {EFF_SCORE, 2'd0}: return 19'd9556;
            {EFF_SCORE, 2'd1}: return 19'd7584;
            {EFF_SCORE, 2'd2}: return 19'd6378;
            {EFF_KILL,  2'd0}: return 19'd6327;
            {EFF_KILL,  2'd1}: return 19'd9556;
            {EFF_KILL,  2'd2}: return 19'd12755;
            {EFF_KILL,  2'd3}: return 19'd19113;
            default:           return 19'd1;
        endcase
    endfunction

endpackage

// File: rtl/sfx_if.sv
// Event, mute and sample bundle between game logic and the sound-effect sequencer.
// The master side raises events and mute; the slave side reports playback and the sample.
interface sfx_if;
    logic        jump_evt;
    logic        score_evt;
    logic        kill_evt;
    logic        mute;
    logic        busy;
    logic [1:0]  effect_id;
    logic [31:0] sample;

    modport master (output jump_evt, score_evt, kill_evt, mute,
                    input  busy, effect_id, sample);
    modport slave  (input  jump_evt, score_evt, kill_evt, mute,
                    output busy, effect_id, sample);
endinterface

// File: rtl/sfx_tone_gen.sv
// Square-wave phase generator: toggles phase every 'half' enabled cycles.
// Latency: load takes effect on the next edge (counter 0, phase 1).
// Backpressure: none; enable simply freezes the counter and phase.
module sfx_tone_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [18:0] half,
    input  logic        enable,
    output logic        phase,
    output logic        wrap
);
    logic [18:0] cnt;
    logic [18:0] half_q;

    // half_q is never zero once loaded, so half_q-1 is the last count of a level
    assign wrap = (cnt == half_q - 19'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 19'd0;
            half_q <= 19'd0;
            phase  <= 1'b0;
        end else if (load) begin
            cnt    <= 19'd0;
            half_q <= half;
            phase  <= 1'b1;
        end else if (enable) begin
            if (wrap) begin
                cnt   <= 19'd0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 19'd1;
            end
        end
    end
endmodule

// File: rtl/sfx_sequencer.sv
// Turns game event pulses into sequenced square-wave notes with gaps and priority preemption.
// Latency: accepted event to first non-zero sample is 1 cycle; sample is registered.
// Backpressure: none; lower-priority events during playback are dropped.
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter logic [31:0] AMPLITUDE  = 32'd10000000,
    parameter logic [23:0] NOTE_TICKS = 24'd5000000,
    parameter logic [23:0] GAP_TICKS  = 24'd500000,
    parameter int          HALF_SHIFT = 0
) (
    input  logic   CLOCK_50,
    input  logic   reset,
    sfx_if.slave   bus
);
    function automatic logic [18:0] eff_half(input logic [1:0] e, input logic [1:0] i);
        logic [18:0] h;
        h = get_half(e, i) >> HALF_SHIFT;
        return (h == 19'd0) ? 19'd1 : h;
    endfunction

    state_t      state, state_n;
    logic [1:0]  eff_q, eff_n, idx_q, idx_n, win_id;
    logic [23:0] note_cnt, note_cnt_n, gap_cnt, gap_cnt_n;
    logic [31:0] sample_q, sample_n;
    logic        accept, tone_load, tone_en, tone_wrap, phase, phase_n;
    logic [18:0] tone_half;

    always_comb begin
        win_id = EFF_NONE;
        if (bus.kill_evt)       win_id = EFF_KILL;
        else if (bus.score_evt) win_id = EFF_SCORE;
        else if (bus.jump_evt)  win_id = EFF_JUMP;
    end

    assign accept = (win_id != EFF_NONE) && ((state == IDLE) || (win_id >= eff_q));

    always_comb begin
        state_n    = state;
        eff_n      = eff_q;
        idx_n      = idx_q;
        note_cnt_n = note_cnt;
        gap_cnt_n  = gap_cnt;
        tone_load  = 1'b0;
        tone_en    = 1'b0;
        tone_half  = eff_half(eff_q, idx_q);
        if (accept) begin
            state_n    = PLAY;
            eff_n      = win_id;
            idx_n      = 2'd0;
            note_cnt_n = 24'd0;
            gap_cnt_n  = 24'd0;
            tone_load  = 1'b1;
            tone_half  = eff_half(win_id, 2'd0);
        end else begin
            case (state)
                PLAY: begin
                    tone_en = 1'b1;
                    if (note_cnt == NOTE_TICKS - 24'd1) begin
                        note_cnt_n = 24'd0;
                        if ({1'b0, idx_q} == note_count(eff_q) - 3'd1) begin
                            state_n = IDLE;
                            eff_n   = EFF_NONE;
                            idx_n   = 2'd0;
                        end else begin
                            state_n   = GAP;
                            gap_cnt_n = 24'd0;
                        end
                    end else begin
                        note_cnt_n = note_cnt + 24'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_TICKS - 24'd1) begin
                        state_n    = PLAY;
                        idx_n      = idx_q + 2'd1;
                        gap_cnt_n  = 24'd0;
                        note_cnt_n = 24'd0;
                        tone_load  = 1'b1;
                        tone_half  = eff_half(eff_q, idx_q + 2'd1);
                    end else begin
                        gap_cnt_n = gap_cnt + 24'd1;
                    end
                end
                default: ;
            endcase
        end
        // sample is registered, so it is built from the phase the tone generator will hold next
        phase_n  = tone_load ? 1'b1 : ((tone_en && tone_wrap) ? ~phase : phase);
        sample_n = 32'd0;
        if (state_n == PLAY && !bus.mute)
            sample_n = phase_n ? AMPLITUDE : (~AMPLITUDE + 32'd1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            eff_q    <= EFF_NONE;
            idx_q    <= 2'd0;
            note_cnt <= 24'd0;
            gap_cnt  <= 24'd0;
            sample_q <= 32'd0;
        end else begin
            state    <= state_n;
            eff_q    <= eff_n;
            idx_q    <= idx_n;
            note_cnt <= note_cnt_n;
            gap_cnt  <= gap_cnt_n;
            sample_q <= sample_n;
        end
    end

    sfx_tone_gen u_tone (
        .clk    (CLOCK_50),
        .reset  (reset),
        .load   (tone_load),
        .half   (tone_half),
        .enable (tone_en),
        .phase  (phase),
        .wrap   (tone_wrap)
    );

    assign bus.busy      = (state != IDLE);
    assign bus.effect_id = eff_q;
    assign bus.sample    = sample_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: directed scenarios plus random events, checked each cycle
// against an arithmetic model of effect position (elapsed cycles -> note, offset, level).
module tb_sfx_sequencer;
    localparam int A  = 100;
    localparam int NT = 40;
    localparam int GT = 4;
    localparam int P  = NT + GT;
    localparam logic [31:0] POS = 32'd100;
    localparam logic [31:0] NEG = 32'hFFFF_FF9C;

    logic CLOCK_50 = 1'b0;
    logic reset;
    sfx_if bus();

    always #10 CLOCK_50 = ~CLOCK_50;

    sfx_sequencer #(
        .AMPLITUDE  (32'd100),
        .NOTE_TICKS (24'd40),
        .GAP_TICKS  (24'd4),
        .HALF_SHIFT (10)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int m_eff = 0;
    int m_e = 0;
    int exp_sample = 0;
    int rom [4][4] = '{'{0, 0, 0, 0}, '{19113, 12755, 0, 0},
                       '{9556, 7584, 6378, 0}, '{6327, 9556, 12755, 19113}};
    int ncount [4] = '{0, 2, 3, 4};

    function automatic int half_of(int eff, int k);
        int h;
        h = rom[eff][k] >> 10;
        return (h < 1) ? 1 : h;
    endfunction

    // Model: an active effect is just its id and the cycles elapsed since its first sample.
    task automatic model_step(input logic j, input logic s, input logic k,
                              input logic mu, input logic rst);
        int w, kk, off;
        if (rst) begin
            m_eff = 0;
            m_e   = 0;
        end else begin
            w = k ? 3 : (s ? 2 : (j ? 1 : 0));
            if (w != 0 && (m_eff == 0 || w >= m_eff)) begin
                m_eff = w;
                m_e   = 0;
            end else if (m_eff != 0) begin
                m_e++;
                if (m_e >= ncount[m_eff] * P - GT) begin
                    m_eff = 0;
                    m_e   = 0;
                end
            end
        end
        exp_sample = 0;
        if (!rst && m_eff != 0 && !mu) begin
            kk  = m_e / P;
            off = m_e % P;
            if (off < NT)
                exp_sample = (((off / half_of(m_eff, kk)) % 2) == 0) ? A : -A;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick(input logic j, input logic s, input logic k);
        bus.jump_evt  = j;
        bus.score_evt = s;
        bus.kill_evt  = k;
        @(posedge CLOCK_50);
        model_step(j, s, k, bus.mute, reset);
        #1;
        bus.jump_evt  = 1'b0;
        bus.score_evt = 1'b0;
        bus.kill_evt  = 1'b0;
        check("busy", {31'b0, bus.busy}, (m_eff != 0) ? 32'd1 : 32'd0);
        check("effect_id", {30'b0, bus.effect_id}, 32'(m_eff));
        check("sample", bus.sample, 32'(exp_sample));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.mute = 1'b0;
        bus.jump_evt = 1'b0;
        bus.score_evt = 1'b0;
        bus.kill_evt = 1'b0;
        idle(3);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_sample", bus.sample, 32'd0);
        reset = 1'b0;
        idle(2);

        // single JUMP effect, with fixed-timing spot checks
        tick(1'b1, 1'b0, 1'b0);
        check("jump_t1", bus.sample, POS);
        for (int i = 2; i <= 90; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (i == 18) check("jump_t18", bus.sample, POS);
            if (i == 19) check("jump_t19", bus.sample, NEG);
            if (i == 41) check("jump_gap", bus.sample, 32'd0);
            if (i == 41) check("jump_gap_busy", {31'b0, bus.busy}, 32'd1);
            if (i == 45) check("jump_n2", bus.sample, POS);
            if (i == 57) check("jump_n2_flip", bus.sample, NEG);
            if (i == 84) check("jump_t84_busy", {31'b0, bus.busy}, 32'd1);
            if (i == 85) check("jump_t85_busy", {31'b0, bus.busy}, 32'd0);
        end

        // simultaneous JUMP and KILL
        tick(1'b1, 1'b0, 1'b1);
        check("jk_eff", {30'b0, bus.effect_id}, 32'd3);
        for (int i = 2; i <= 7; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (i == 6) check("jk_t6", bus.sample, POS);
            if (i == 7) check("jk_t7", bus.sample, NEG);
        end
        idle(200);

        // KILL with SCORE mid-note (dropped) then KILL mid-GAP (restart)
        tick(1'b0, 1'b0, 1'b1);
        idle(10);
        tick(1'b0, 1'b1, 1'b0);
        check("kill_keep", {30'b0, bus.effect_id}, 32'd3);
        idle(30);
        tick(1'b0, 1'b0, 1'b1);
        check("kill_regap", bus.sample, POS);
        idle(200);

        // SCORE preempts JUMP
        tick(1'b1, 1'b0, 1'b0);
        idle(20);
        tick(1'b0, 1'b1, 1'b0);
        check("score_pre_eff", {30'b0, bus.effect_id}, 32'd2);
        check("score_pre_smp", bus.sample, POS);
        idle(140);

        // muted SCORE
        bus.mute = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        check("mute_busy", {31'b0, bus.busy}, 32'd1);
        idle(140);
        bus.mute = 1'b0;

        // reset during KILL note 2, then JUMP
        tick(1'b0, 1'b0, 1'b1);
        idle(P + 10);
        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        check("rst_mid_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_mid_eff", {30'b0, bus.effect_id}, 32'd0);
        reset = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        check("post_rst_jump", bus.sample, POS);
        idle(90);

        // retrigger on the last-note terminal cycle
        tick(1'b1, 1'b0, 1'b0);
        idle(83);
        tick(1'b1, 1'b0, 1'b0);
        check("term_retrig_busy", {31'b0, bus.busy}, 32'd1);
        check("term_retrig_smp", bus.sample, POS);
        idle(90);

        // random events, mute and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) bus.mute = ~bus.mute;
            reset = ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, 59) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 119) == 0);
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Upstream stage of the board audio output path: turns single-cycle game events (jump, score, kill) into short multi-note square-wave sound effects.
- Emits one signed 32-bit sample word that the audio output stage adds to the codec stream on both channels.
- Replaces the single-tone-per-level scheme with sequenced note lists, priority preemption and inter-note gaps.

Parameters:
- AMPLITUDE, 32'd10000000, magnitude of the square-wave sample.
- NOTE_TICKS, 24'd5000000, clock cycles per note (100 ms at 50 MHz).
- GAP_TICKS, 24'd500000, silent cycles between consecutive notes.
- HALF_SHIFT, 0, right-shift applied to ROM half-periods (simulation speed-up). Effective half-period is max(ROM>>HALF_SHIFT, 1).

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-high reset
- jump_evt  in  1  one-cycle pulse: start JUMP effect
- score_evt  in  1  one-cycle pulse: start SCORE effect
- kill_evt  in  1  one-cycle pulse: start KILL effect
- mute  in  1  forces sample to 0; sequencing continues
- busy  out  1  high while an effect is playing (PLAY or GAP)
- effect_id  out  2  0 NONE, 1 JUMP, 2 SCORE, 3 KILL
- sample  out  32  signed sample word, registered

Behaviour:
- One clock (CLOCK_50). reset is synchronous and active-high.
- Reset values: state IDLE, busy 0, effect_id 0, sample 0, all counters 0, phase 0.

Note ROM (half-periods in cycles, in play order):
- JUMP: 19113, 12755.
- SCORE: 9556, 7584, 6378.
- KILL: 6327, 9556, 12755, 19113.

States: IDLE, PLAY, GAP.

Event arbitration, each cycle:
- Priority KILL > SCORE > JUMP among simultaneous pulses.
- The winning event is accepted when its priority is >= the current effect_id, or when in IDLE.
- A lower-priority event during playback is dropped.
- An accepted event restarts the sequence at note 0, from any state.

Accept at cycle t. At t+1:
- state PLAY, effect_id set, busy 1.
- note_idx 0, tone_cnt 0, note_cnt 0, phase 1.
- sample = +AMPLITUDE (0 if mute).
- Latency from event to first non-zero sample: 1 cycle.

PLAY:
- tone_cnt counts 0..half-1. At half-1: tone_cnt clears and phase toggles. Each level therefore lasts exactly half cycles.
- note_cnt counts 0..NOTE_TICKS-1.
- At NOTE_TICKS-1, if this is not the last note: go to GAP with gap_cnt 0.
- At NOTE_TICKS-1 on the last note: go to IDLE. The next cycle has busy 0, effect_id 0, sample 0.

GAP:
- sample 0.
- gap_cnt counts 0..GAP_TICKS-1, then goes to PLAY with note_idx+1, counters 0, phase 1.

Sample rules:
- sample = 0 in IDLE, in GAP, or when mute=1.
- Otherwise sample = phase ? +AMPLITUDE : -AMPLITUDE (two's complement, 32-bit).

Boundary conditions:
- An event on the same cycle as the last-note terminal count: the event wins and playback restarts.
- reset asserted mid-effect returns to reset values on the next edge.
- Counter comparisons use ==, so no counter wraps.

Decomposition:
- Package sfx_pkg holds:
  - state enum (IDLE, PLAY, GAP);
  - effect id constants;
  - per-effect note counts (2, 3, 4);
  - note ROM as a constant function get_half(effect, idx) returning 19-bit half-periods.
- One sub-module, sfx_tone_gen:
  - loadable half-period counter plus phase flip-flop;
  - inputs: load, half, enable;
  - output: phase.

Test Plan (HALF_SHIFT=10, NOTE_TICKS=40, GAP_TICKS=4, AMPLITUDE=100; effective halves: JUMP 18, 12; SCORE 9, 7, 6; KILL 6, 9, 12, 18):
- jump_evt pulse at t:
  - sample +100 for t+1..t+18, then -100 for 18 cycles;
  - 0 for 4 cycles after cycle t+40;
  - second note alternates every 12 cycles;
  - busy falls 1 cycle after the last note ends (t+85);
  - effect_id 1 throughout playback.
- jump_evt and kill_evt in the same cycle: effect_id 3, first half-period 6.
- kill_evt playing, score_evt pulse mid-note: ignored, note timing unchanged. kill_evt pulse mid-GAP: restarts at note 0, half-period 6.
- score_evt during JUMP: preempts at the next cycle, effect_id 2, half-period 9, note_idx 0.
- mute=1 for a whole SCORE effect: sample stays 0, busy/effect_id timing identical to the unmuted run.
- reset asserted during KILL note 2: next cycle busy 0, effect_id 0, sample 0. A jump_evt right after reset plays normally.
